// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_port_arbiter
// Brief    : Serialises an instruction-fetch read port and a data read/write
//            port onto one SRAM controller, with a watchdog abort.
// Revision : 1.0
// ============================================================================
module sram_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_rd_en,
    input  logic [ADDR_W-1:0] p0_addr,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_ready,
    input  logic              p1_rd_en,
    input  logic              p1_wr_en,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_ready,
    output logic              mem_r_en,
    output logic              mem_w_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              err
);

    localparam int               CNT_W  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
    localparam logic             C_FIXED = (FIXED_PRIO != 0);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_next;
    logic              r_last_grant;
    logic              r_grant;
    logic              r_op_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_p0_rdata;
    logic [DATA_W-1:0] r_p1_rdata;
    logic              r_p0_ready;
    logic              r_p1_ready;
    logic              r_err;

    logic w_p0_req;
    logic w_p1_req;
    logic w_pick_p1;
    logic w_timeout;
    logic w_finish;

    assign w_p0_req  = p0_rd_en;
    assign w_p1_req  = p1_rd_en | p1_wr_en;
    // On a tie, port 1 wins when fixed priority is set or port 0 was served last.
    assign w_pick_p1 = w_p1_req & (~w_p0_req | C_FIXED | ~r_last_grant);
    assign w_timeout = (r_cnt == C_LAST);
    assign w_finish  = (r_state == S_BUSY) & (mem_ready | w_timeout);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_p0_req | w_p1_req) w_next = S_BUSY;
            S_BUSY:  if (mem_ready | w_timeout) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem_r_en  = (r_state == S_BUSY) & ~r_op_wr;
        mem_w_en  = (r_state == S_BUSY) &  r_op_wr;
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
        p0_rdata  = r_p0_rdata;
        p1_rdata  = r_p1_rdata;
        p0_ready  = r_p0_ready;
        p1_ready  = r_p1_ready;
        err       = r_err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_op_wr      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cnt        <= '0;
            r_p0_rdata   <= '0;
            r_p1_rdata   <= '0;
            r_p0_ready   <= 1'b0;
            r_p1_ready   <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_p0_ready <= 1'b0;
            r_p1_ready <= 1'b0;
            r_err      <= 1'b0;
            if ((r_state == S_IDLE) && (w_p0_req || w_p1_req)) begin
                r_grant      <= w_pick_p1;
                r_last_grant <= w_pick_p1;
                r_op_wr      <= w_pick_p1 & p1_wr_en;
                r_addr       <= w_pick_p1 ? p1_addr : p0_addr;
                r_wdata      <= w_pick_p1 ? p1_wdata : '0;
                r_cnt        <= '0;
            end else if (r_state == S_BUSY) begin
                r_cnt <= r_cnt + C_ONE;
            end
            // A completed controller cycle takes precedence over the watchdog.
            if (w_finish) begin
                r_err <= ~mem_ready;
                if (r_grant) begin
                    r_p1_ready <= 1'b1;
                    r_p1_rdata <= (mem_ready & ~r_op_wr) ? mem_rdata : '0;
                end else begin
                    r_p0_ready <= 1'b1;
                    r_p0_rdata <= mem_ready ? mem_rdata : '0;
                end
            end
        end
    end

endmodule
`default_nettype wire
